fetch_stage: RTL and testbench

Instruction-fetch stage of the 16-bit pipelined CPU. Holds the architectural PC, reads the instruction memory through a hit/ready port, and loads the IF/ID pipeline register. That register feeds the decode-stage PC control. Redirect (`pc_target`/`branch`) and halt information return from decode, and stalls come from the hazard unit.

---
 rtl/fetch_stage.sv | 124 ++++++++++++
 tb/tb_fetch_stage.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//
// Instruction-fetch stage of the 16-bit pipelined CPU. Holds the architectural
// PC, fetches from instruction memory through a hit/ready port and loads the
// IF/ID pipeline register consumed by decode.
//
// Ports:
//   clk          clock, all state changes on the rising edge
//   rst          synchronous active-high reset
//   stall        hazard-unit stall: PC, IF/ID and halted hold
//   branch       taken-branch redirect from decode (overrides stall)
//   pc_target    redirect address, bit 0 forced to 0
//   imem_req     fetch request (low while halted or in reset)
//   imem_addr    fetch address (current PC)
//   imem_data    instruction word, valid when imem_rdy=1
//   imem_rdy     memory has data for imem_addr this cycle
//   ifid_instr   IF/ID instruction word
//   ifid_pc      address of ifid_instr
//   ifid_pc_inc  ifid_pc + 2 (branch offset base)
//   ifid_valid   IF/ID holds a real instruction
//   halted       a HLT was fetched and fetching is stopped
// -----------------------------------------------------------------------------
module fetch_stage #(
    parameter logic [15:0] RESET_PC     = 16'h0000,
    parameter logic [15:0] BUBBLE_INSTR = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        branch,
    input  logic [15:0] pc_target,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_data,
    input  logic        imem_rdy,
    output logic [15:0] ifid_instr,
    output logic [15:0] ifid_pc,
    output logic [15:0] ifid_pc_inc,
    output logic        ifid_valid,
    output logic        halted
);

    localparam logic [3:0] HLT_OPCODE = 4'hF;

    logic [15:0] pc_reg,          pc_next;
    logic [15:0] ifid_instr_reg,  ifid_instr_next;
    logic [15:0] ifid_pc_reg,     ifid_pc_next;
    logic [15:0] ifid_pc_inc_reg, ifid_pc_inc_next;
    logic        ifid_valid_reg,  ifid_valid_next;
    logic        halted_reg,      halted_next;

    logic [15:0] pc_plus2;
    logic        xfer;

    // 16-bit add, carry discarded so 16'hFFFE wraps to 16'h0000.
    assign pc_plus2  = pc_reg + 16'd2;

    assign imem_addr = pc_reg;
    assign imem_req  = !halted_reg && !rst;
    assign xfer      = imem_req && imem_rdy && !stall && !branch;

    always_comb begin
        pc_next          = pc_reg;
        ifid_instr_next  = ifid_instr_reg;
        ifid_pc_next     = ifid_pc_reg;
        ifid_pc_inc_next = ifid_pc_inc_reg;
        ifid_valid_next  = ifid_valid_reg;
        halted_next      = halted_reg;

        if (branch) begin
            // Redirect squashes everything younger, including a fetched HLT
            // and any pending miss for the old PC.
            pc_next          = {pc_target[15:1], 1'b0};
            ifid_instr_next  = BUBBLE_INSTR;
            ifid_pc_next     = 16'h0000;
            ifid_pc_inc_next = 16'h0000;
            ifid_valid_next  = 1'b0;
            halted_next      = 1'b0;
        end else if (stall) begin
            // Hold everything; imem_rdy is ignored and the address is re-presented.
        end else if (xfer) begin
            ifid_instr_next  = imem_data;
            ifid_pc_next     = pc_reg;
            ifid_pc_inc_next = pc_plus2;
            ifid_valid_next  = 1'b1;
            if (imem_data[15:12] == HLT_OPCODE) begin
                // PC parks on the HLT address.
                halted_next = 1'b1;
            end else begin
                pc_next = pc_plus2;
            end
        end else begin
            // Miss or halted: insert a bubble, keep the last ifid_pc/pc_inc.
            ifid_instr_next = BUBBLE_INSTR;
            ifid_valid_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_reg          <= {RESET_PC[15:1], 1'b0};
            ifid_instr_reg  <= BUBBLE_INSTR;
            ifid_pc_reg     <= 16'h0000;
            ifid_pc_inc_reg <= 16'h0000;
            ifid_valid_reg  <= 1'b0;
            halted_reg      <= 1'b0;
        end else begin
            pc_reg          <= pc_next;
            ifid_instr_reg  <= ifid_instr_next;
            ifid_pc_reg     <= ifid_pc_next;
            ifid_pc_inc_reg <= ifid_pc_inc_next;
            ifid_valid_reg  <= ifid_valid_next;
            halted_reg      <= halted_next;
        end
    end

    assign ifid_instr  = ifid_instr_reg;
    assign ifid_pc     = ifid_pc_reg;
    assign ifid_pc_inc = ifid_pc_inc_reg;
    assign ifid_valid  = ifid_valid_reg;
    assign halted      = halted_reg;

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
//
// Self-checking bench for fetch_stage: directed scenarios followed by a
// randomized run, all compared against a cycle-level reference model.
// -----------------------------------------------------------------------------
module tb_fetch_stage;

    localparam logic [15:0] BUB = 16'h0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        branch = 1'b0;
    logic [15:0] pc_target = 16'h0000;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic [15:0] imem_data;
    logic        imem_rdy = 1'b1;
    logic [15:0] ifid_instr;
    logic [15:0] ifid_pc;
    logic [15:0] ifid_pc_inc;
    logic        ifid_valid;
    logic        halted;

    // Address holding an explicit HLT (odd value = none). Otherwise the
    // memory returns address ^ 16'h1000; during a miss it returns junk
    // that looks like a HLT so that ignoring it is exercised.
    logic [15:0] hlt_addr = 16'hFFFF;

    int errors = 0;
    int checks = 0;

    // Reference model state.
    logic [15:0] m_pc, m_instr, m_ipc, m_inc;
    logic        m_valid, m_halt;

    fetch_stage #(.RESET_PC(16'h0000), .BUBBLE_INSTR(BUB)) dut (
        .clk(clk), .rst(rst), .stall(stall), .branch(branch),
        .pc_target(pc_target), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_data(imem_data), .imem_rdy(imem_rdy), .ifid_instr(ifid_instr),
        .ifid_pc(ifid_pc), .ifid_pc_inc(ifid_pc_inc), .ifid_valid(ifid_valid),
        .halted(halted)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] mem_word(input logic [15:0] a, input logic [15:0] h);
        return (a == h) ? 16'hF000 : (a ^ 16'h1000);
    endfunction

    assign imem_data = imem_rdy ? mem_word(imem_addr, hlt_addr) : 16'hF0F0;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs at the falling edge, check combinational
    // outputs, let the edge happen, advance the model, check state.
    task automatic step(input logic r, input logic s, input logic b,
                        input logic [15:0] t, input logic rdy);
        logic [15:0] w;
        @(negedge clk);
        rst = r; stall = s; branch = b; pc_target = t; imem_rdy = rdy;
        #1;
        chk("req_pre", {15'd0, imem_req}, {15'd0, !m_halt && !r});
        @(posedge clk);
        if (r) begin
            m_pc = 16'h0000; m_instr = BUB; m_ipc = 0; m_inc = 0;
            m_valid = 0; m_halt = 0;
        end else if (b) begin
            m_pc = t & 16'hFFFE; m_instr = BUB; m_ipc = 0; m_inc = 0;
            m_valid = 0; m_halt = 0;
        end else if (s) begin
            // nothing moves
        end else if (!m_halt && rdy) begin
            w = mem_word(m_pc, hlt_addr);
            m_instr = w; m_ipc = m_pc; m_inc = m_pc + 16'd2; m_valid = 1;
            if (w[15:12] == 4'hF) m_halt = 1;
            else m_pc = m_pc + 16'd2;
        end else begin
            m_instr = BUB; m_valid = 0;
        end
        #1;
        chk("imem_addr", imem_addr, m_pc);
        chk("imem_req", {15'd0, imem_req}, {15'd0, !m_halt && !r});
        chk("ifid_instr", ifid_instr, m_instr);
        chk("ifid_pc", ifid_pc, m_ipc);
        chk("ifid_pc_inc", ifid_pc_inc, m_inc);
        chk("ifid_valid", {15'd0, ifid_valid}, {15'd0, m_valid});
        chk("halted", {15'd0, halted}, {15'd0, m_halt});
        $display("cyc t=%0t rst=%0d stall=%0d br=%0d rdy=%0d addr=%h ifid=%h/%h/%h v=%0d halt=%0d",
                 $time, r, s, b, rdy, imem_addr, ifid_pc, ifid_instr, ifid_pc_inc,
                 ifid_valid, halted);
    endtask

    initial begin
        m_pc = 0; m_instr = BUB; m_ipc = 0; m_inc = 0; m_valid = 0; m_halt = 0;

        // Reset held two cycles.
        step(1, 0, 0, 16'h0, 1);
        step(1, 0, 0, 16'h0, 1);
        chk("rst_req", {15'd0, imem_req}, 16'd0);
        chk("rst_valid", {15'd0, ifid_valid}, 16'd0);
        chk("rst_instr", ifid_instr, BUB);
        chk("rst_pc", ifid_pc, 16'h0000);
        chk("rst_addr", imem_addr, 16'h0000);

        // Hitting stream: 0, 2, 4.
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 16'h0, 1);
            chk("stream_pc", ifid_pc, 16'(2 * i));
            chk("stream_instr", ifid_instr, 16'(16'h1000 + 2 * i));
            chk("stream_valid", {15'd0, ifid_valid}, 16'd1);
        end

        // Stall two cycles with IF/ID at 4, memory missing: no bubble.
        for (int i = 0; i < 2; i++) begin
            step(0, 1, 0, 16'h0, i[0]);
            chk("stall_pc", ifid_pc, 16'h0004);
            chk("stall_valid", {15'd0, ifid_valid}, 16'd1);
            chk("stall_addr", imem_addr, 16'h0006);
        end

        // Three miss cycles at 6, then the transfer.
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 16'h0, 0);
            chk("miss_valid", {15'd0, ifid_valid}, 16'd0);
            chk("miss_addr", imem_addr, 16'h0006);
        end
        step(0, 0, 0, 16'h0, 1);
        chk("miss_xfer_pc", ifid_pc, 16'h0006);
        chk("miss_xfer_valid", {15'd0, ifid_valid}, 16'd1);

        // Branch with stall: redirect wins, odd target rounds down.
        step(0, 1, 1, 16'h0041, 1);
        chk("br_stall_addr", imem_addr, 16'h0040);
        chk("br_stall_valid", {15'd0, ifid_valid}, 16'd0);

        // HLT at 0x10.
        hlt_addr = 16'h0010;
        step(0, 0, 1, 16'h0010, 1);
        step(0, 0, 0, 16'h0, 1);
        chk("hlt_halted", {15'd0, halted}, 16'd1);
        chk("hlt_valid", {15'd0, ifid_valid}, 16'd1);
        chk("hlt_instr", ifid_instr, 16'hF000);
        chk("hlt_req", {15'd0, imem_req}, 16'd0);
        for (int i = 0; i < 2; i++) begin
            step(0, 0, 0, 16'h0, 1);
            chk("hlt_bubble", {15'd0, ifid_valid}, 16'd0);
            chk("hlt_addr_hold", imem_addr, 16'h0010);
        end
        step(0, 0, 1, 16'h0020, 1);
        chk("hlt_clear", {15'd0, halted}, 16'd0);
        chk("hlt_resume_req", {15'd0, imem_req}, 16'd1);
        step(0, 0, 0, 16'h0, 1);
        chk("hlt_resume_pc", ifid_pc, 16'h0020);

        // Wrap around the top of the address space.
        hlt_addr = 16'hFFFF;
        step(0, 0, 1, 16'hFFFE, 1);
        step(0, 0, 0, 16'h0, 1);
        chk("wrap_pc", ifid_pc, 16'hFFFE);
        chk("wrap_inc", ifid_pc_inc, 16'h0000);
        chk("wrap_addr", imem_addr, 16'h0000);

        // Randomized traffic, with a planted HLT and occasional reset.
        hlt_addr = 16'h0100;
        for (int i = 0; i < 400; i++) begin
            logic r, s, b, rdy;
            logic [15:0] t;
            r   = ($urandom_range(0, 99) < 2);
            s   = ($urandom_range(0, 99) < 25);
            b   = ($urandom_range(0, 99) < 10);
            rdy = ($urandom_range(0, 99) < 70);
            t   = ($urandom_range(0, 3) == 0) ? 16'h00FA : 16'($urandom);
            step(r, s, b, t, rdy);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
